// File: rtl/bs_seq_pkg.sv
// Shared types and widths for the bit-serial program sequencer.
package bs_seq_pkg;

    localparam int unsigned INSTR_W = 3;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ADVANCE,
        HALT,
        ERROR
    } seq_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  data;
    } prog_word_t;

endpackage

// File: rtl/bs_prog_mem.sv
// Program store: register file, one synchronous write port, one combinational
// read port, asynchronously cleared to zero by reset.
module bs_prog_mem
    import bs_seq_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  prog_word_t      i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output prog_word_t      o_rdata
);

    prog_word_t mem_q [DEPTH];

    // Storage array with async clear.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/bs_program_sequencer.sv
// Program sequencer: issues stored {instr, data} words to the bit-serial core
// with a start pulse and advances on the core's PC-increment strobe.
// Optional watchdog on the WAIT state: define BS_SEQ_WATCHDOG_EN.
module bs_program_sequencer
    import bs_seq_pkg::*;
#(
    parameter  int unsigned PROG_DEPTH  = 16,
`ifdef BS_SEQ_WATCHDOG_EN
    parameter  int unsigned WDOG_CYCLES = 64,
`endif
    localparam int unsigned AW          = $clog2(PROG_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic               i_step,
    input  logic               i_loop,
    input  logic [AW-1:0]      i_last_addr,
    input  logic               i_load_en,
    input  logic [AW-1:0]      i_load_addr,
    input  logic [INSTR_W-1:0] i_load_instr,
    input  logic [DATA_W-1:0]  i_load_data,
    input  logic               i_core_pcincr,
    output logic [INSTR_W-1:0] o_instr,
    output logic [DATA_W-1:0]  o_data_switch,
    output logic               o_start,
    output logic [AW-1:0]      o_pc,
    output logic               o_busy,
    output logic               o_halted,
    output logic               o_error
);

    seq_state_e         state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [AW-1:0]      next_pc;
    logic [AW-1:0]      rd_addr;
    logic               step_q, step_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               mem_we;
    prog_word_t         rd_word;
    prog_word_t         wr_word;

`ifdef BS_SEQ_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           error_q, error_d;
    logic           wdog_expired;

    assign wdog_expired = (wdog_q == WDW'(WDOG_CYCLES - 1));
`endif

    assign wr_word = '{instr: i_load_instr, data: i_load_data};

    bs_prog_mem #(.DEPTH(PROG_DEPTH)) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (mem_we),
        .i_waddr (i_load_addr),
        .i_wdata (wr_word),
        .i_raddr (rd_addr),
        .o_rdata (rd_word)
    );

    // Next-state, program counter and core-facing output decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        step_d   = step_q;
        instr_d  = instr_q;
        data_d   = data_q;
        mem_we   = 1'b0;
        rd_addr  = pc_q;
        next_pc  = (pc_q == i_last_addr) ? '0 : pc_q + AW'(1);

        case (state_q)
            IDLE: begin
                if (i_run || i_step) begin
                    state_d = ISSUE;
                    step_d  = !i_run;
                    instr_d = rd_word.instr;
                    data_d  = rd_word.data;
                end else begin
                    mem_we  = i_load_en;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (i_core_pcincr) begin
                    state_d = ADVANCE;
`ifdef BS_SEQ_WATCHDOG_EN
                end else if (wdog_expired) begin
                    state_d = ERROR;
`endif
                end
            end
            ADVANCE: begin
                rd_addr = next_pc;
                if ((pc_q == i_last_addr) && !i_loop) begin
                    state_d = HALT;
                end else begin
                    pc_d = next_pc;
                    if (step_q || !i_run) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                        instr_d = rd_word.instr;
                        data_d  = rd_word.data;
                    end
                end
            end
            HALT: begin
                mem_we = i_load_en;
                if (!i_run) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            end
            ERROR: begin
                if (!i_run && !i_step) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        start_d  = (state_d == ISSUE);
        busy_d   = (state_d == ISSUE) || (state_d == WAIT) || (state_d == ADVANCE);
        halted_d = (state_d == HALT);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            step_q   <= 1'b0;
            instr_q  <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            step_q   <= step_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

`ifdef BS_SEQ_WATCHDOG_EN
    // Watchdog counter: cleared on the way into WAIT, counts WAIT cycles.
    always_comb begin
        wdog_d  = wdog_q;
        if (state_q == ISSUE) begin
            wdog_d = '0;
        end else if (state_q == WAIT) begin
            wdog_d = wdog_q + WDW'(1);
        end
        error_d = (state_d == ERROR);
    end

    // Watchdog registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    assign o_instr       = instr_q;
    assign o_data_switch = data_q;
    assign o_start       = start_q;
    assign o_pc          = pc_q;
    assign o_busy        = busy_q;
    assign o_halted      = halted_q;

endmodule

// File: tb/tb_bs_program_sequencer.sv
// Directed self-checking bench for bs_program_sequencer with a simple core
// model that returns the PC-increment strobe four cycles after each start.
module tb_bs_program_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       loop = 1'b0;
    logic [3:0] last_addr = 4'd0;
    logic       load_en = 1'b0;
    logic [3:0] load_addr = 4'd0;
    logic [2:0] load_instr = 3'd0;
    logic [7:0] load_data = 8'd0;
    logic       pcincr;
    logic [2:0] o_instr;
    logic [7:0] o_data_switch;
    logic       o_start;
    logic [3:0] o_pc;
    logic       o_busy;
    logic       o_halted;
    logic       o_error;

    int n_checks = 0;
    int n_fails  = 0;

    // Core model / start monitor state
    logic       core_en = 1'b1;
    int         core_cnt = 0;
    int         start_cnt = 0;
    int         cyc = 0;
    logic [2:0] cap_instr [64];
    logic [7:0] cap_data  [64];
    logic [3:0] cap_pc    [64];
    int         cap_cyc   [64];

    int base;
    int n;
    logic [3:0] pc_snap;

    bs_program_sequencer #(.PROG_DEPTH(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_run         (run),
        .i_step        (step),
        .i_loop        (loop),
        .i_last_addr   (last_addr),
        .i_load_en     (load_en),
        .i_load_addr   (load_addr),
        .i_load_instr  (load_instr),
        .i_load_data   (load_data),
        .i_core_pcincr (pcincr),
        .o_instr       (o_instr),
        .o_data_switch (o_data_switch),
        .o_start       (o_start),
        .o_pc          (o_pc),
        .o_busy        (o_busy),
        .o_halted      (o_halted),
        .o_error       (o_error)
    );

    always #5 clk = ~clk;

    // Core model and issued-word capture, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            core_cnt = 0;
            pcincr   = 1'b0;
        end else begin
            pcincr = 1'b0;
            if (o_start) begin
                if (start_cnt < 64) begin
                    cap_instr[start_cnt] = o_instr;
                    cap_data[start_cnt]  = o_data_switch;
                    cap_pc[start_cnt]    = o_pc;
                    cap_cyc[start_cnt]   = cyc;
                end
                start_cnt++;
                core_cnt = 4;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) pcincr = core_en;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [2:0] ins, input logic [7:0] d);
        load_addr  = a;
        load_instr = ins;
        load_data  = d;
        load_en    = 1'b1;
        @(negedge clk);
        load_en    = 1'b0;
    endtask

    task automatic wait_halted(input string tag, input int budget);
        int k = 0;
        while (!o_halted && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(o_halted), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (o_busy && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        int k = 0;
        while (start_cnt < target && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(start_cnt >= target), 32'd1);
    endtask

    task automatic do_step(input string tag);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_idle(tag, 50);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_start",  32'(o_start), 32'd0);
        check("rst_instr",  32'(o_instr), 32'd0);
        check("rst_data",   32'(o_data_switch), 32'd0);
        check("rst_pc",     32'(o_pc), 32'd0);
        check("rst_busy",   32'(o_busy), 32'd0);
        check("rst_halted", 32'(o_halted), 32'd0);
        check("rst_error",  32'(o_error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        load_word(4'd0, 3'd1, 8'hA5);
        load_word(4'd1, 3'd2, 8'h3C);
        load_word(4'd2, 3'd4, 8'h00);
        last_addr = 4'd2;
        loop      = 1'b0;

        // Run to halt
        base = start_cnt;
        run  = 1'b1;
        @(posedge clk); #2;
        check("run_start_lat", 32'(o_start), 32'd1);
        check("run_busy",      32'(o_busy), 32'd1);
        wait_halted("run_halt_timeout", 200);
        check("run_nstarts", 32'(start_cnt - base), 32'd3);
        check("w0_instr", 32'(cap_instr[base]),   32'd1);
        check("w0_data",  32'(cap_data[base]),    32'hA5);
        check("w1_instr", 32'(cap_instr[base+1]), 32'd2);
        check("w1_data",  32'(cap_data[base+1]),  32'h3C);
        check("w2_instr", 32'(cap_instr[base+2]), 32'd4);
        check("w2_data",  32'(cap_data[base+2]),  32'h00);
        check("issue_spacing", 32'(cap_cyc[base+1] - cap_cyc[base]), 32'd6);
        check("halt_pc",   32'(o_pc), 32'd2);
        check("halt_busy", 32'(o_busy), 32'd0);

        run = 1'b0;
        @(negedge clk);
        check("unhalt_halted", 32'(o_halted), 32'd0);
        check("unhalt_pc",     32'(o_pc), 32'd0);

        // Loop, then drop run during WAIT with an attempted load write
        loop = 1'b1;
        base = start_cnt;
        run  = 1'b1;
        wait_starts("loop_timeout", base + 4, 200);
        @(negedge clk);
        run = 1'b0;
        load_word(4'd0, 3'd7, 8'hFF);
        wait_idle("drop_idle_timeout", 50);
        check("loop_w3_instr", 32'(cap_instr[base+3]), 32'd1);
        check("loop_w3_data",  32'(cap_data[base+3]),  32'hA5);
        check("loop_w3_pc",    32'(cap_pc[base+3]),    32'd0);
        check("drop_pc",       32'(o_pc), 32'd1);
        check("drop_nstarts",  32'(start_cnt - base), 32'd4);
        check("drop_halted",   32'(o_halted), 32'd0);

        // Single steps through the rest of the program and back to 0
        base = start_cnt;
        do_step("step1_timeout");
        check("step1_nstarts", 32'(start_cnt - base), 32'd1);
        check("step1_instr",   32'(cap_instr[base]), 32'd2);
        check("step1_data",    32'(cap_data[base]),  32'h3C);
        check("step1_pc",      32'(o_pc), 32'd2);
        do_step("step2_timeout");
        check("step2_instr",   32'(cap_instr[base+1]), 32'd4);
        check("step2_pc",      32'(o_pc), 32'd0);
        do_step("step3_timeout");
        check("step3_instr",   32'(cap_instr[base+2]), 32'd1);
        check("step3_data",    32'(cap_data[base+2]),  32'hA5);
        check("step3_pc",      32'(o_pc), 32'd1);
        check("step3_busy",    32'(o_busy), 32'd0);
        check("step_nstarts",  32'(start_cnt - base), 32'd3);

        // Reset in the middle of WAIT
        base = start_cnt;
        run  = 1'b1;
        wait_starts("rstwait_timeout", base + 1, 20);
        repeat (2) @(negedge clk);
        check("prerst_instr", 32'(o_instr), 32'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_start", 32'(o_start), 32'd0);
        check("midrst_instr", 32'(o_instr), 32'd0);
        check("midrst_data",  32'(o_data_switch), 32'd0);
        check("midrst_pc",    32'(o_pc), 32'd0);
        check("midrst_busy",  32'(o_busy), 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = start_cnt;
        do_step("poststep_timeout");
        check("cleared_instr", 32'(cap_instr[base]), 32'd0);
        check("cleared_data",  32'(cap_data[base]),  32'd0);
        check("poststep_pc",   32'(o_pc), 32'd1);

        // Core never answers
        core_en = 1'b0;
        base    = start_cnt;
        pc_snap = o_pc;
        run     = 1'b1;
        wait_starts("wd_start_timeout", base + 1, 20);
`ifdef BS_SEQ_WATCHDOG_EN
        n = 0;
        while (!o_error && n < 200) begin @(negedge clk); n++; end
        check("wd_cycles", 32'(n), 32'd65);
        check("wd_error",  32'(o_error), 32'd1);
        check("wd_busy",   32'(o_busy), 32'd0);
        check("wd_pc",     32'(o_pc), 32'(pc_snap));
        run = 1'b0;
        @(negedge clk);
        check("wd_clr_error", 32'(o_error), 32'd0);
        check("wd_clr_busy",  32'(o_busy), 32'd0);
        check("wd_nstarts",   32'(start_cnt - base), 32'd1);
`else
        repeat (100) @(negedge clk);
        check("nowd_error",   32'(o_error), 32'd0);
        check("nowd_busy",    32'(o_busy), 32'd1);
        check("nowd_pc",      32'(o_pc), 32'(pc_snap));
        check("nowd_nstarts", 32'(start_cnt - base), 32'd1);
        run   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
        core_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
